// File: rtl/sequenciador_medidas_hcsr04_pkg.sv
// sequenciador_medidas_hcsr04_pkg: state codes (equal to db_estado) and shared widths
package sequenciador_medidas_hcsr04_pkg;
   localparam int BCD_W = 12;
   localparam logic [3:0] DB_INVALIDO = 4'b1110;
   typedef enum logic [3:0] {
      INICIAL        = 4'b0000,
      ESPERA_PERIODO = 4'b0001,
      ACIONA         = 4'b0010,
      ESPERA_PRONTO  = 4'b0011,
      ARMAZENA       = 4'b0100,
      CALCULA        = 4'b0101,
      TIMEOUT_ST     = 4'b0110,
      ERRO           = 4'b1101,
      FINAL          = 4'b1111
   } estado_t;
endpackage

// File: rtl/mediana3.sv
// mediana3: combinational median of three packed-BCD values (BCD orders like binary)
module mediana3
   import sequenciador_medidas_hcsr04_pkg::*;
(
   input  logic [BCD_W-1:0] a_i,
   input  logic [BCD_W-1:0] b_i,
   input  logic [BCD_W-1:0] c_i,
   output logic [BCD_W-1:0] m_o
);
   logic [BCD_W-1:0] mn, mx, t;
   always_comb begin
      mn  = (a_i < b_i) ? a_i : b_i;
      mx  = (a_i < b_i) ? b_i : a_i;
      t   = (mx < c_i) ? mx : c_i;
      m_o = (mn > t) ? mn : t;
   end
endmodule

// File: rtl/sequenciador_medidas_hcsr04_fd.sv
// sequenciador_medidas_hcsr04_fd: shared period/timeout counter, sample store and median register
module sequenciador_medidas_hcsr04_fd
   import sequenciador_medidas_hcsr04_pkg::*;
#(
   parameter int PERIODO    = 2500000,
   parameter int TIMEOUT    = 1500000,
   parameter int MAX_FALHAS = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             zera_i,
   input  logic             conta_i,
   input  logic             captura_i,
   input  logic             armazena_i,
   input  logic             calcula_i,
   input  logic             falha_i,
   input  logic [BCD_W-1:0] medida_i,
   output logic             fim_periodo_o,
   output logic             fim_timeout_o,
   output logic             ultima_o,
   output logic             falhas_max_o,
   output logic [BCD_W-1:0] distancia_o
);
   localparam int MAXC = (PERIODO > TIMEOUT) ? PERIODO : TIMEOUT;
   localparam int CW   = $clog2(MAXC);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       falhas_q, falhas_d;
   logic [BCD_W-1:0] amostra_q [3];
   logic [BCD_W-1:0] amostra_d [3];
   logic [BCD_W-1:0] dist_q, dist_d, med;

   mediana3 u_mediana (.a_i(amostra_q[0]), .b_i(amostra_q[1]), .c_i(amostra_q[2]), .m_o(med));

   // one counter serves both waits: every entry to a counting state comes from a clearing state
   always_comb begin
      cnt_d    = conta_i ? cnt_q + 1'b1 : '0;
      idx_d    = (zera_i || calcula_i) ? 2'd0 : armazena_i ? idx_q + 2'd1 : idx_q;
      falhas_d = (zera_i || armazena_i) ? 4'd0 : falha_i ? falhas_q + 4'd1 : falhas_q;
      for (int i = 0; i < 3; i++)
         amostra_d[i] = (captura_i && idx_q == 2'(i)) ? medida_i : amostra_q[i];
      dist_d   = calcula_i ? med : dist_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         falhas_q  <= '0;
         amostra_q <= '{default: '0};
         dist_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         falhas_q  <= falhas_d;
         amostra_q <= amostra_d;
         dist_q    <= dist_d;
      end
   end

   assign fim_periodo_o = cnt_q == CW'(PERIODO - 1);
   assign fim_timeout_o = cnt_q == CW'(TIMEOUT - 1);
   assign ultima_o      = idx_q == 2'd2;
   assign falhas_max_o  = falhas_q == 4'(MAX_FALHAS - 1);
   assign distancia_o   = dist_q;
endmodule

// File: rtl/sequenciador_medidas_hcsr04_uc.sv
// sequenciador_medidas_hcsr04_uc: control FSM sequencing trigger, wait, capture and median
module sequenciador_medidas_hcsr04_uc
   import sequenciador_medidas_hcsr04_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       pronto_medida,
   input  logic       fim_periodo_i,
   input  logic       fim_timeout_i,
   input  logic       ultima_i,
   input  logic       falhas_max_i,
   output logic       zera_o,
   output logic       conta_o,
   output logic       captura_o,
   output logic       armazena_o,
   output logic       calcula_o,
   output logic       falha_o,
   output logic       medir_o,
   output logic       reset_sensor_o,
   output logic       valido_o,
   output logic       erro_o,
   output logic [3:0] db_estado_o
);
   estado_t est_q, est_d;

   always_ff @(posedge clock)
      est_q <= reset ? INICIAL : est_d;

   always_comb begin
      est_d       = INICIAL;
      db_estado_o = est_q;
      case (est_q)
         INICIAL:        est_d = ESPERA_PERIODO;
         ESPERA_PERIODO: est_d = fim_periodo_i ? ACIONA : ESPERA_PERIODO;
         ACIONA:         est_d = ESPERA_PRONTO;
         ESPERA_PRONTO:  est_d = pronto_medida ? ARMAZENA : fim_timeout_i ? TIMEOUT_ST : ESPERA_PRONTO;
         ARMAZENA:       est_d = ultima_i ? CALCULA : ESPERA_PERIODO;
         CALCULA:        est_d = FINAL;
         FINAL:          est_d = ESPERA_PERIODO;
         TIMEOUT_ST:     est_d = falhas_max_i ? ERRO : ESPERA_PERIODO;
         ERRO:           est_d = ERRO;
         default:        db_estado_o = DB_INVALIDO;
      endcase
      if (!ligar) est_d = INICIAL;
   end

   // datapath side effects are suppressed when ligar drops, so distancia is kept
   assign zera_o         = est_q == INICIAL;
   assign conta_o        = est_q == ESPERA_PERIODO || est_q == ESPERA_PRONTO;
   assign captura_o      = est_q == ESPERA_PRONTO && pronto_medida && ligar;
   assign armazena_o     = est_q == ARMAZENA;
   assign calcula_o      = est_q == CALCULA && ligar;
   assign falha_o        = est_q == TIMEOUT_ST;
   assign medir_o        = est_q == ACIONA;
   assign valido_o       = est_q == FINAL;
   assign erro_o         = est_q == ERRO;
   assign reset_sensor_o = est_q == TIMEOUT_ST || (est_q == ESPERA_PRONTO && !ligar);
endmodule

// File: rtl/sequenciador_medidas_hcsr04.sv
// sequenciador_medidas_hcsr04: periodic HC-SR04 trigger with timeout retry and 3-sample median filter
module sequenciador_medidas_hcsr04
   import sequenciador_medidas_hcsr04_pkg::*;
#(
   parameter int PERIODO    = 2500000,
   parameter int TIMEOUT    = 1500000,
   parameter int MAX_FALHAS = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ligar,
   input  logic             pronto_medida,
   input  logic [BCD_W-1:0] medida,
   output logic             medir,
   output logic             reset_sensor,
   output logic [BCD_W-1:0] distancia,
   output logic             valido,
   output logic             erro,
   output logic [3:0]       db_estado
);
   logic zera, conta, captura, armazena, calcula, falha;
   logic fim_periodo, fim_timeout, ultima, falhas_max;

   sequenciador_medidas_hcsr04_uc u_uc (
      .clock(clock), .reset(reset), .ligar(ligar), .pronto_medida(pronto_medida),
      .fim_periodo_i(fim_periodo), .fim_timeout_i(fim_timeout), .ultima_i(ultima),
      .falhas_max_i(falhas_max), .zera_o(zera), .conta_o(conta), .captura_o(captura),
      .armazena_o(armazena), .calcula_o(calcula), .falha_o(falha), .medir_o(medir),
      .reset_sensor_o(reset_sensor), .valido_o(valido), .erro_o(erro), .db_estado_o(db_estado)
   );

   sequenciador_medidas_hcsr04_fd #(.PERIODO(PERIODO), .TIMEOUT(TIMEOUT), .MAX_FALHAS(MAX_FALHAS)) u_fd (
      .clock(clock), .reset(reset), .zera_i(zera), .conta_i(conta), .captura_i(captura),
      .armazena_i(armazena), .calcula_i(calcula), .falha_i(falha), .medida_i(medida),
      .fim_periodo_o(fim_periodo), .fim_timeout_o(fim_timeout), .ultima_o(ultima),
      .falhas_max_o(falhas_max), .distancia_o(distancia)
   );
endmodule

// File: tb/tb_sequenciador_medidas_hcsr04.sv
// tb_sequenciador_medidas_hcsr04: randomized sensor responder checked against an event-level model
module tb_sequenciador_medidas_hcsr04;
   localparam int P = 10;
   localparam int T = 20;
   localparam int M = 2;

   logic        clock = 0, reset = 1, ligar = 0, pronto_medida = 0;
   logic [11:0] medida = 0;
   logic        medir, reset_sensor, valido, erro;
   logic [11:0] distancia;
   logic [3:0]  db_estado;

   int testes = 0, falhas = 0;
   int medir_vistos = 0, valido_vistos = 0, medir_exp = 0, valido_exp = 0, falhas_m = 0;
   logic [11:0] dist_m = 0;
   logic [11:0] amostras [$];

   sequenciador_medidas_hcsr04 #(.PERIODO(P), .TIMEOUT(T), .MAX_FALHAS(M)) dut (
      .clock(clock), .reset(reset), .ligar(ligar), .pronto_medida(pronto_medida),
      .medida(medida), .medir(medir), .reset_sensor(reset_sensor), .distancia(distancia),
      .valido(valido), .erro(erro), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (!reset && medir) medir_vistos++;
      if (!reset && valido) valido_vistos++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testes++;
      if (obs !== exp) begin
         falhas++;
         $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [11:0] bcd_rand();
      return {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
   endfunction

   function automatic logic [11:0] mediana_ref();
      logic [11:0] s [$];
      s = amostras;
      s.sort();
      return s[1];
   endfunction

   // waits for the trigger from the first cycle of the period wait; returns with the DUT in ACIONA
   task automatic espera_medir();
      int n;
      n = 0;
      if ($urandom_range(1) == 1) begin
         pronto_medida = 1;
         medida = bcd_rand();
      end
      while (!medir && n < P + 5) begin
         tick();
         pronto_medida = 0;
         n++;
      end
      verifica("atraso_medir", n, P);
      verifica("db_aciona", db_estado, 4'b0010);
      medir_exp++;
   endtask

   task automatic rodada(input bit responde, input int atraso, input logic [11:0] val);
      int n;
      espera_medir();
      tick();
      verifica("db_espera_pronto", db_estado, 4'b0011);
      if (responde) begin
         for (int i = 1; i < atraso; i++) tick();
         pronto_medida = 1;
         medida = val;
         tick();
         pronto_medida = 0;
         medida = bcd_rand();
         verifica("reset_sensor_captura", reset_sensor, 0);
         verifica("db_armazena", db_estado, 4'b0100);
         falhas_m = 0;
         amostras.push_back(val);
         if (amostras.size() == 3) begin
            tick();
            verifica("db_calcula", db_estado, 4'b0101);
            tick();
            dist_m = mediana_ref();
            amostras.delete();
            valido_exp++;
            verifica("valido_final", valido, 1);
            verifica("distancia_mediana", distancia, dist_m);
         end
         tick();
         verifica("db_volta_periodo", db_estado, 4'b0001);
      end else begin
         n = 0;
         while (!reset_sensor && n < T + 5) begin
            tick();
            n++;
         end
         verifica("atraso_timeout", n, T);
         verifica("db_timeout", db_estado, 4'b0110);
         falhas_m++;
         tick();
         if (falhas_m == M) begin
            verifica("erro_alto", erro, 1);
            verifica("db_erro", db_estado, 4'b1101);
            repeat (3 * P) tick();
            verifica("erro_mantido", erro, 1);
            ligar = 0;
            tick();
            verifica("erro_limpo", erro, 0);
            verifica("db_inicial_pos_erro", db_estado, 4'b0000);
            verifica("distancia_retida_erro", distancia, dist_m);
            ligar = 1;
            falhas_m = 0;
            amostras.delete();
            tick();
         end
         verifica("db_pos_timeout", db_estado, 4'b0001);
      end
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      verifica("reset_medir", medir, 0);
      verifica("reset_reset_sensor", reset_sensor, 0);
      verifica("reset_valido", valido, 0);
      verifica("reset_erro", erro, 0);
      verifica("reset_distancia", distancia, 0);
      verifica("reset_db", db_estado, 4'b0000);
      reset = 0;
      ligar = 1;
      tick();
      verifica("db_espera_periodo", db_estado, 4'b0001);

      rodada(1, 3, 12'h123);
      rodada(1, 1, 12'h045);
      rodada(1, 7, 12'h300);
      verifica("distancia_123", distancia, 12'h123);
      verifica("medir_tres_pulsos", medir_vistos, 3);
      rodada(1, 2, 12'h099);
      rodada(1, 5, 12'h100);
      rodada(1, 9, 12'h099);
      verifica("distancia_099", distancia, 12'h099);
      for (int i = 0; i < 3; i++) rodada(1, 4 + i, 12'h250);
      verifica("distancia_250", distancia, 12'h250);

      rodada(0, 0, 0);
      rodada(0, 0, 0);
      rodada(0, 0, 0);
      rodada(1, 6, bcd_rand());
      rodada(0, 0, 0);
      verifica("sem_erro_apos_boa", erro, 0);
      rodada(1, T, bcd_rand());
      rodada(1, T, bcd_rand());

      for (int i = 0; i < 30; i++)
         rodada($urandom_range(3) != 0, $urandom_range(T, 1), bcd_rand());

      // abort while waiting for pronto
      espera_medir();
      tick();
      tick();
      ligar = 0;
      #1;
      verifica("reset_sensor_abort", reset_sensor, 1);
      tick();
      verifica("db_inicial_abort", db_estado, 4'b0000);
      verifica("distancia_retida_abort", distancia, dist_m);
      amostras.delete();
      falhas_m = 0;
      ligar = 1;
      tick();
      verifica("db_periodo_pos_abort", db_estado, 4'b0001);

      // synchronous reset arriving during CALCULA
      rodada(1, 2, bcd_rand());
      rodada(1, 3, bcd_rand());
      espera_medir();
      tick();
      pronto_medida = 1;
      medida = bcd_rand();
      tick();
      pronto_medida = 0;
      tick();
      verifica("db_calcula_reset", db_estado, 4'b0101);
      reset = 1;
      tick();
      reset = 0;
      verifica("distancia_zerada", distancia, 0);
      verifica("valido_apos_reset", valido, 0);
      verifica("db_apos_reset", db_estado, 4'b0000);
      repeat (5) tick();

      verifica("total_medir", medir_vistos, medir_exp);
      verifica("total_valido", valido_vistos, valido_exp);
      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end
endmodule

// File: doc/sequenciador_medidas_hcsr04.md
Name: sequenciador_medidas_hcsr04

Overview:
Drives the HC-SR04 interface unit from upstream and consumes its result downstream. While enabled, it pulses `medir` once per period and waits for the interface `pronto`. On a timeout it resets the sensor interface and retries. After three good samples it outputs their median as a filtered BCD distance with a one-cycle valid strobe.

Parameters:
PERIODO, 2500000, clock cycles spent in ESPERA_PERIODO before each trigger (50 ms at 50 MHz); minimum 2.
TIMEOUT, 1500000, clock cycles allowed in ESPERA_PRONTO before a timeout (30 ms); minimum 2.
MAX_FALHAS, 3, consecutive timeouts that cause the ERRO state; range 1..15.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ligar  in  1  enable; level-sensitive
pronto_medida  in  1  `pronto` from the HC-SR04 interface (1-cycle pulse)
medida  in  12  3-digit packed-BCD distance from the interface; stable when pronto_medida=1
medir  out  1  1-cycle measurement request to the interface
reset_sensor  out  1  1-cycle pulse that resets the interface after a timeout or abort
distancia  out  12  median of the last 3 samples, packed BCD; registered
valido  out  1  1-cycle strobe: distancia updated
erro  out  1  high in ERRO state
db_estado  out  4  debug state code

Behaviour:
- Reset is synchronous: on a clock edge with reset=1, state=INICIAL; period/timeout counters, sample index, falhas, sample registers and distancia all clear to 0.
- After reset, all outputs are 0 and db_estado=0000.
- Moore outputs:
  - medir=1 only in ACIONA.
  - valido=1 only in FINAL.
  - erro=1 only in ERRO.
  - reset_sensor=1 in TIMEOUT_ST, and also in ESPERA_PRONTO when ligar=0 (Mealy abort).
- States, with db_estado code and transitions:
  - INICIAL (0000): ligar=1 -> ESPERA_PERIODO; clears idx, falhas and the counter.
  - ESPERA_PERIODO (0001): counts up; when count=PERIODO-1 -> ACIONA (exactly PERIODO cycles in this state).
  - ACIONA (0010): -> ESPERA_PRONTO; clears the timeout counter.
  - ESPERA_PRONTO (0011):
    - pronto_medida=1 -> ARMAZENA, and medida is captured into amostra[idx] on that edge.
    - Otherwise, at count=TIMEOUT-1 -> TIMEOUT_ST.
    - If pronto and the last timeout count coincide, pronto wins.
  - ARMAZENA (0100): idx++, falhas=0; if the new idx=3 -> CALCULA, else -> ESPERA_PERIODO.
  - CALCULA (0101): distancia <= median(amostra0..2) on exit edge; idx=0; -> FINAL.
  - FINAL (1111): -> ESPERA_PERIODO.
  - TIMEOUT_ST (0110): falhas++; if the new falhas=MAX_FALHAS -> ERRO, else -> ESPERA_PERIODO. Already-captured samples are kept.
  - ERRO (1101): held while ligar=1.
  - Any unencoded state: db_estado=1110, next state INICIAL.
- ligar=0 in any state -> INICIAL on the next edge. This clears idx, falhas and erro; distancia is retained.
- Latency: the edge that samples the third pronto=1 is edge N. ARMAZENA runs in cycle N+1, CALCULA in N+2, and valido plus the new distancia appear in cycle N+3.
- Median is max(min(a,b), min(max(a,b), c)) using unsigned 12-bit compares. This is valid because packed BCD orders like binary; medida is never converted.
- pronto_medida outside ESPERA_PRONTO is ignored and causes no capture.
- The counters are sized to hold max(PERIODO, TIMEOUT)-1. falhas is 4 bits.

Decomposition:
- Shared package holds:
  - state encodings (4-bit, equal to the db_estado codes above);
  - the db_estado invalid code 1110;
  - BCD width constant 12.
- One sub-module: mediana3, combinational 3-input median over 12 bits, instantiated in the datapath.
- The control and datapath split follows the team's uc/fd convention: sequenciador_medidas_hcsr04_uc and sequenciador_medidas_hcsr04_fd.

Test Plan:
Bench parameters: PERIODO=10, TIMEOUT=20, MAX_FALHAS=2.
1. reset=1 for 2 edges, then ligar=1 -> medir first pulses 10 cycles after entering ESPERA_PERIODO; it is 1 cycle wide, and db_estado walks 0000->0001->0010->0011.
2. Reply pronto with medida=0x123, 0x045, 0x300 -> valido high 3 cycles after the third pronto; distancia=0x123; exactly 3 medir pulses were issued.
3. Samples 0x099, 0x100, 0x099 -> distancia=0x099. Samples 0x250, 0x250, 0x250 -> 0x250 (BCD ordering and equal-value ties).
4. No pronto after one medir -> reset_sensor pulses in cycle 20 after ACIONA; next medir follows 10 cycles later. A second consecutive timeout -> erro=1, db_estado=1101, and no further medir. ligar=0 -> INICIAL, erro=0.
5. Timeout, then a good sample, then a timeout -> no ERRO (falhas cleared by ARMAZENA). pronto on the exact final timeout cycle -> capture, no reset_sensor.
6. ligar=0 during ESPERA_PRONTO -> reset_sensor=1 that cycle, INICIAL next, distancia unchanged. reset=1 mid-CALCULA -> distancia=0 and valido never asserts.
